fetch_controller: RTL and testbench

Sequences instruction fetch for the pipeline front end. Issues in-order read requests to instruction memory, forwards returned instructions with their PCs into the two-entry instruction queue, and never lets queued plus in-flight fetches exceed queue capacity. On a branch redirect it flushes the queue, discards stale in-flight responses and restarts fetch at the target.

---
 rtl/fetch_controller_if.sv | 27 ++
 rtl/fetch_controller.sv | 111 +++++++++++
 tb/tb_fetch_controller.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// Fetch-side bus bundle: instruction-memory request/response, instruction-queue
// push/flush, decode dequeue and branch redirect.
interface fetch_controller_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        q_enqueue;
    logic [31:0] q_instr;
    logic [31:0] q_pc;
    logic        q_flush;
    logic        deq;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        busy;

    modport master (
        output mem_req, mem_addr, q_enqueue, q_instr, q_pc, q_flush, busy,
        input  mem_gnt, mem_rvalid, mem_rdata, deq, branch_valid, branch_target
    );

    modport slave (
        input  mem_req, mem_addr, q_enqueue, q_instr, q_pc, q_flush, busy,
        output mem_gnt, mem_rvalid, mem_rdata, deq, branch_valid, branch_target
    );
endinterface

// File: rtl/fetch_controller.sv
// In-order instruction fetch sequencer: keeps queued plus in-flight fetches
// within queue capacity and discards stale responses after a redirect.
module fetch_controller #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    fetch_controller_if.master bus
);
    localparam int unsigned     CW        = $clog2(DEPTH + 1);
    localparam int unsigned     PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]     DEPTH_SUM = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0]   LAST_SLOT = PW'(DEPTH - 1);

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    state_t        state_reg, state_next;
    logic [31:0]   pc_reg, pc_next;
    logic [CW-1:0] occ_reg, occ_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] drop_cnt_reg, drop_cnt_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [31:0]   pc_fifo_reg [DEPTH];
    logic [DEPTH-1:0] slot_we;

    logic grant;
    logic enqueue;
    logic deq_ok;
    logic dropping;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PW'(1);
    endfunction

    // Request window depends only on registers, so mem_req has no input path.
    assign bus.mem_req  = (state_reg == RUN) &&
                          (({1'b0, occ_reg} + {1'b0, outstanding_reg}) < DEPTH_SUM);
    assign bus.mem_addr = pc_reg;
    assign bus.busy     = (outstanding_reg != '0) || (state_reg != RUN);
    assign bus.q_flush  = bus.branch_valid;

    assign grant    = bus.mem_req && bus.mem_gnt;
    assign dropping = (drop_cnt_reg != '0);
    assign enqueue  = bus.mem_rvalid && !dropping && !bus.branch_valid;
    assign deq_ok   = bus.deq && (occ_reg != '0);

    assign bus.q_enqueue = enqueue;
    assign bus.q_instr   = enqueue ? bus.mem_rdata : '0;
    assign bus.q_pc      = enqueue ? pc_fifo_reg[rd_ptr_reg] : '0;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = grant && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_we[i]) pc_fifo_reg[i] <= pc_reg;
        end
    end

    always_comb begin
        outstanding_next = outstanding_reg + CW'(grant) - CW'(bus.mem_rvalid);
        wr_ptr_next      = grant ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next      = bus.mem_rvalid ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        pc_next          = grant ? pc_reg + 32'd4 : pc_reg;
        occ_next         = occ_reg + CW'(enqueue) - CW'(deq_ok);
        drop_cnt_next    = drop_cnt_reg;
        state_next       = state_reg;

        if (bus.mem_rvalid && dropping) drop_cnt_next = drop_cnt_reg - CW'(1);

        // A redirect wins: everything still in flight, including a grant
        // taken this very cycle, becomes stale.
        if (bus.branch_valid) begin
            pc_next       = bus.branch_target & 32'hFFFF_FFFC;
            occ_next      = '0;
            drop_cnt_next = outstanding_next;
        end

        case (state_reg)
            BOOT:  state_next = RUN;
            RUN:   if (bus.branch_valid && (outstanding_next != '0)) state_next = DRAIN;
            DRAIN: if (!bus.branch_valid && (drop_cnt_next == '0)) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= BOOT;
            pc_reg          <= RESET_PC;
            occ_reg         <= '0;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            occ_reg         <= occ_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
        end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: behavioural memory, occupancy model and
// a scoreboard of expected queue pushes.
module tb_fetch_controller;
    logic clk;
    logic rst;
    fetch_controller_if bus();

    fetch_controller #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: 0 = BOOT, 1 = RUN, 2 = DRAIN
    int          st_m, occ_m, out_m, drop_m;
    logic [31:0] pc_m;
    logic [31:0] inflight[$];
    logic [63:0] exp_q[$];
    bit          gnt_prev;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        bus.mem_gnt       = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.deq           = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = 32'h0;
        bus.mem_rdata     = $urandom();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_mem_req",   bus.mem_req,   1'b0);
        chk("rst_mem_addr",  bus.mem_addr,  32'h0000_0000);
        chk("rst_q_enqueue", bus.q_enqueue, 1'b0);
        chk("rst_q_instr",   bus.q_instr,   32'h0);
        chk("rst_q_pc",      bus.q_pc,      32'h0);
        chk("rst_q_flush",   bus.q_flush,   1'b0);
        chk("rst_busy",      bus.busy,      1'b1);
        $display("t=%0t reset applied", $time);
        rst = 1'b0;
        st_m = 0; occ_m = 0; out_m = 0; drop_m = 0; pc_m = 32'h0;
        gnt_prev = 1'b0;
        inflight.delete();
        exp_q.delete();
    endtask

    // One clock cycle: drive inputs, predict, compare, advance the model.
    task automatic tick(input bit g, input bit rv, input bit dq, input bit br,
                        input logic [31:0] tgt);
        bit          exp_req, grant, exp_enq;
        logic [31:0] a;
        logic [63:0] e;
        int          out_nx;
        exp_req = (st_m == 1) && (occ_m + out_m < 2);
        grant   = g && exp_req;
        a       = 32'h0;
        bus.mem_gnt       = g;
        bus.mem_rvalid    = rv;
        bus.deq           = dq;
        bus.branch_valid  = br;
        bus.branch_target = tgt;
        bus.mem_rdata     = $urandom();
        if (rv) begin
            if (inflight.size() == 0) begin
                errors++;
                $error("FAIL rvalid_idle observed=rvalid expected=no_outstanding_fetch");
            end else begin
                a = inflight.pop_front();
                bus.mem_rdata = data_of(a);
                if (!br && drop_m == 0) exp_q.push_back({a, data_of(a)});
            end
        end
        #1;
        chk("mem_req",   bus.mem_req,  exp_req);
        chk("mem_addr",  bus.mem_addr, pc_m);
        chk("busy",      bus.busy,     (out_m != 0) || (st_m != 1));
        chk("q_flush",   bus.q_flush,  br);
        exp_enq = (exp_q.size() != 0);
        chk("q_enqueue", bus.q_enqueue, exp_enq);
        if (exp_enq) begin
            e = exp_q.pop_front();
            chk("q_pc",    bus.q_pc,    e[63:32]);
            chk("q_instr", bus.q_instr, e[31:0]);
        end else begin
            chk("q_pc_idle",    bus.q_pc,    32'h0);
            chk("q_instr_idle", bus.q_instr, 32'h0);
        end
        $display("t=%0t req=%0b gnt=%0b addr=%h rvalid=%0b enq=%0b q_pc=%h deq=%0b br=%0b tgt=%h",
                 $time, bus.mem_req, grant, bus.mem_addr, rv, bus.q_enqueue, bus.q_pc, dq, br, tgt);

        out_nx = out_m + int'(grant) - int'(rv);
        if (grant) inflight.push_back(pc_m);
        if (br) begin
            drop_m = out_nx;
            occ_m  = 0;
            pc_m   = tgt & 32'hFFFF_FFFC;
            if (st_m == 0)      st_m = 1;
            else if (st_m == 1) st_m = (out_nx != 0) ? 2 : 1;
        end else begin
            if (rv && drop_m != 0) drop_m--;
            occ_m = occ_m + int'(exp_enq) - int'(dq && occ_m > 0);
            if (grant) pc_m = pc_m + 32'd4;
            if (st_m == 0)                    st_m = 1;
            else if (st_m == 2 && drop_m == 0) st_m = 1;
        end
        out_m    = out_nx;
        gnt_prev = grant;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);

        // Streaming: grant always, response one cycle after grant, deq tied high
        do_reset();
        repeat (14) tick(1'b1, gnt_prev, 1'b1, 1'b0, 32'h0);

        // Back-pressure: no deq fills the queue, one deq re-opens one fetch at 0x8
        do_reset();
        repeat (6) tick(1'b1, gnt_prev, 1'b0, 1'b0, 32'h0);
        chk("bp_stalled", bus.mem_req, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect with two in flight, then a stale grant and a retarget while draining
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0400);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        // Branch, grant and response in the same cycle
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0200);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        // Address wrap and low target bits forced to zero
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0103);
        chk("target_aligned", bus.mem_addr, 32'h0000_0100);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        // Reset mid-operation with a fetch in flight and one queued entry
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
